// File: rtl/thirty_two_iterative_divider.sv
// Signed restoring divider: one quotient bit per clock, magnitude datapath with final sign fix-up.
// Latency: result_ready 34 cycles after an accepted start (WIDTH=32), 1 cycle for a zero divisor.
// Backpressure: start is accepted only in IDLE/DONE; a start while busy is dropped without effect.
module thirty_two_iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             result_ready,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             divisor_zero;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    // Magnitude of a two's-complement value; the most negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    assign accept       = start && ((state == IDLE) || (state == DONE));
    assign divisor_zero = (divisor == '0);
    assign last_iter    = (count == CNT_W'(WIDTH - 1));

    // Trial subtract is one bit wider than the operands so its sign bit flags a borrow.
    assign shifted = {acc, q_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = divisor_zero ? DONE : DIVIDE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DIVIDE: begin
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state == DIVIDE) || (state == FIX);
        result_ready = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            q_reg       <= '0;
            dvs_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            acc     <= '0;
            q_reg   <= magnitude(dividend);
            dvs_mag <= magnitude(divisor);
            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r  <= dividend[WIDTH-1];
            // A zero divisor short-circuits straight to the result registers.
            if (divisor_zero) begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end
        end else if (state == DIVIDE) begin
            count <= count + CNT_W'(1);
            if (!trial[WIDTH]) begin
                acc   <= trial[WIDTH-1:0];
                q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc   <= shifted[WIDTH-1:0];
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            quotient    <= sign_q ? negate(q_reg) : q_reg;
            remainder   <= sign_r ? negate(acc) : acc;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thirty_two_iterative_divider.sv
// Directed and random checks of the signed iterative divider against an arithmetic reference model.
module tb_thirty_two_iterative_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        result_ready;
    logic        div_by_zero;

    int total  = 0;
    int passes = 0;

    thirty_two_iterative_divider #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .busy         (busy),
        .result_ready (result_ready),
        .div_by_zero  (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder takes the dividend's sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Waits for result_ready; lat counts edges since the start edge, busy_low counts idle gaps.
    task automatic wait_ready(input int lat0, output int lat, output int busy_low);
        lat      = lat0;
        busy_low = 0;
        while (result_ready !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            step();
            lat++;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
    endtask

    // Checks the result present in the result_ready cycle against the model.
    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input int busy_low);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        model(a, b, eq, er, ez);
        check({tag, " ready"}, {31'd0, result_ready}, 32'd1);
        check({tag, " latency"}, lat, ez ? 32'd1 : 32'd34);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({tag, " busy gaps"}, busy_low, ez ? 32'd1 : 32'd0);
        check({tag, " busy at ready"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic div_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int busy_low;
        launch(a, b);
        if (b == 32'd0) begin
            wait_ready(1, lat, busy_low);
            busy_low = busy_low + 1;
        end else begin
            wait_ready(1, lat, busy_low);
        end
        check_result(tag, a, b, lat, busy_low);
        step();
        check({tag, " strobe single"}, {31'd0, result_ready}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          busy_low;
        int          ready_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) step();
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, result_ready}, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        step();

        div_check("100/7", 32'd100, 32'd7);
        div_check("-100/7", 32'hFFFF_FF9C, 32'd7);
        div_check("100/-7", 32'd100, 32'hFFFF_FFF9);
        div_check("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
        div_check("min/1", 32'h8000_0000, 32'd1);
        div_check("5/0", 32'd5, 32'd0);
        div_check("9/3", 32'd9, 32'd3);
        div_check("-7/-7", 32'hFFFF_FFF9, 32'hFFFF_FFF9);
        div_check("3/100", 32'd3, 32'd100);

        // Start while busy must be ignored.
        launch(32'd100, 32'd7);
        repeat (8) step();
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        step();
        start    = 1'b0;
        wait_ready(10, lat, busy_low);
        check_result("ignored start", 32'd100, 32'd7, lat, busy_low);
        step();

        // Reset mid-operation aborts without a result strobe.
        launch(32'd100, 32'd7);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort ready", {31'd0, result_ready}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort dbz", {31'd0, div_by_zero}, 32'd0);
        ready_seen = 0;
        repeat (29) begin
            step();
            if (result_ready === 1'b1) ready_seen++;
        end
        check("abort no strobe", ready_seen, 32'd0);
        div_check("20/6", 32'd20, 32'd6);

        // Back-to-back: new start accepted in the DONE cycle.
        launch(32'd100, 32'd7);
        wait_ready(1, lat, busy_low);
        check_result("b2b first", 32'd100, 32'd7, lat, busy_low);
        launch(32'hFFFF_FFF7, 32'd3);
        check("b2b strobe drop", {31'd0, result_ready}, 32'd0);
        check("b2b busy", {31'd0, busy}, 32'd1);
        wait_ready(1, lat, busy_low);
        check_result("b2b second", 32'hFFFF_FFF7, 32'd3, lat, busy_low);
        step();

        // Back-to-back zero divisors give consecutive strobes.
        launch(32'd5, 32'd0);
        check("dbz b2b first", {31'd0, result_ready}, 32'd1);
        launch(32'd7, 32'd0);
        check("dbz b2b second", {31'd0, result_ready}, 32'd1);
        check("dbz b2b flag", {31'd0, div_by_zero}, 32'd1);
        step();
        check("dbz b2b drop", {31'd0, result_ready}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case (i % 5)
                0: rb = 32'($urandom_range(1, 20));
                1: rb = 32'd0 - 32'($urandom_range(1, 20));
                2: rb = $urandom;
                3: rb = {16'd0, 16'($urandom)};
                default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            endcase
            div_check("random", ra, rb);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
